// File: rtl/wb_pkg.sv
// Shared Wishbone widths, wait-counter sizing and the slave FSM state type.
package wb_pkg;

    localparam int WB_ADR_W   = 32;
    localparam int WB_DAT_W   = 32;
    localparam int WB_SEL_W   = 4;
    localparam int WAIT_CNT_W = 4;

    localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_TURN = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_sram_array.sv
// Single-port word storage with per-byte write enables and a registered read.
// Contents are never reset; the read register follows whatever address the
// port sees, so data for address A is available one cycle after A is presented.
module wb_sram_array
    import wb_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic                i_clk,
    input  logic [IDX_W-1:0]    i_addr,
    input  logic                i_we,
    input  logic [WB_SEL_W-1:0] i_be,
    input  logic [WB_DAT_W-1:0] i_wdata,
    output logic [WB_DAT_W-1:0] o_rdata
);

    logic [WB_DAT_W-1:0] mem [WORDS];
    logic [WB_DAT_W-1:0] rdata_q;

    // Byte-lane writes and the registered read share the one address port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < WB_SEL_W; b++) begin
                if (i_be[b]) begin
                    mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        rdata_q <= mem[i_addr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave in front of a byte-writable SRAM. A request is
// latched in IDLE, waits WAIT_CYCLES cycles, terminates with ack or err in
// RESP, then spends one TURN cycle ignoring the bus before returning to IDLE.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [WB_ADR_W-1:0] i_wb_adr,
    input  logic [WB_DAT_W-1:0] i_wb_dat,
    input  logic [WB_SEL_W-1:0] i_wb_sel,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    output logic [WB_DAT_W-1:0] o_wb_dat,
    output logic                o_wb_ack,
    output logic                o_wb_err
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    wb_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [WB_ADR_W-1:0]   adr_q, adr_d;
    logic [WB_DAT_W-1:0]   dat_q, dat_d;
    logic [WB_SEL_W-1:0]   sel_q, sel_d;
    logic                  we_q, we_d;

    logic                  in_range;
    logic                  resp_live;
    logic [IDX_W-1:0]      mem_addr;
    logic                  mem_we;
    logic [WB_DAT_W-1:0]   mem_rdata;
    logic                  unused_adr_lsbs;

    // Next-state logic: latch in IDLE, count down in WAIT, terminate in RESP,
    // and fall back to IDLE whenever the master drops cyc before termination.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    adr_d = i_wb_adr;
                    dat_d = i_wb_dat;
                    sel_d = i_wb_sel;
                    we_d  = i_wb_we;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = i_wb_cyc ? ST_TURN : ST_IDLE;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and latched-request registers; reset abandons any pending access.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
        end
    end

    // Decode, termination and read-data steering. The array address follows
    // the live bus in IDLE so a zero-wait read has its data ready in RESP.
    always_comb begin
        in_range  = ((adr_q >> (IDX_W + 2)) == '0);
        resp_live = (state_q == ST_RESP) && i_wb_cyc && i_rst_n;
        o_wb_ack  = resp_live && in_range;
        o_wb_err  = resp_live && !in_range;
        mem_we    = o_wb_ack && we_q;
        mem_addr  = (state_q == ST_IDLE) ? i_wb_adr[IDX_W+1:2] : adr_q[IDX_W+1:2];
        o_wb_dat  = (o_wb_ack && !we_q) ? mem_rdata : '0;
    end

    assign unused_adr_lsbs = ^adr_q[1:0];

    wb_sram_array #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_addr  (mem_addr),
        .i_we    (mem_we),
        .i_be    (sel_q),
        .i_wdata (dat_q),
        .o_rdata (mem_rdata)
    );

endmodule

// File: doc/wb_sram_slave.md
WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words of storage (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before acknowledge (0..15).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 i_wb_adr  input  32  byte address from bus master.
REQ-007 i_wb_dat  input  32  write data.
REQ-008 i_wb_sel  input  4  byte lane enables; bit n selects bits [8n+7:8n].
REQ-009 i_wb_we  input  1  1 = write, 0 = read.
REQ-010 i_wb_cyc  input  1  bus cycle active.
REQ-011 i_wb_stb  input  1  strobe; request valid when cyc and stb are both 1.
REQ-012 o_wb_dat  output  32  read data; valid only in the ack cycle, 0 otherwise.
REQ-013 o_wb_ack  output  1  single-cycle normal termination.
REQ-014 o_wb_err  output  1  single-cycle error termination.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP, TURN.
REQ-016 IDLE: on cyc & stb, SHALL latch adr, dat, sel, we; go to WAIT with counter = WAIT_CYCLES, or directly to RESP if WAIT_CYCLES = 0.
REQ-017 WAIT: counter SHALL decrement every cycle; on counter = 1 go to RESP.
REQ-018 Latency: ack/err SHALL assert exactly WAIT_CYCLES+1 cycles after the cycle the request is sampled in IDLE.
REQ-019 RESP: SHALL assert exactly one of o_wb_ack or o_wb_err for one cycle, then go to TURN.
REQ-020 TURN: SHALL ignore cyc/stb for one cycle, then go to IDLE; the next request is sampled no earlier than 2 cycles after ack.
REQ-021 In-range: latched adr < MEM_WORDS*4; word index = adr[log2(MEM_WORDS)+1:2]; adr[1:0] ignored.
REQ-022 Out-of-range address SHALL terminate with o_wb_err, o_wb_dat = 0, and no memory write.
REQ-023 Write SHALL update only lanes with sel bit 1, committed in the RESP cycle; sel = 0000 SHALL ack with no change.
REQ-024 Read SHALL drive o_wb_dat with the stored word in the RESP cycle, all 32 bits regardless of sel.
REQ-025 Abort: cyc = 0 in WAIT or RESP SHALL return the FSM to IDLE with no ack/err and no write.
REQ-026 stb dropping while cyc stays 1 after sampling SHALL NOT abort; the latched request completes.
REQ-027 o_wb_ack and o_wb_err SHALL never be 1 together; neither SHALL assert unless cyc = 1.
REQ-028 No output SHALL be X after reset.

Reset
REQ-029 i_rst_n = 0 at a rising edge SHALL force state IDLE, counter 0, o_wb_ack 0, o_wb_err 0, o_wb_dat 0.
REQ-030 Reset mid-transaction SHALL discard the pending access: no write, no ack/err.
REQ-031 Memory contents SHALL NOT be reset.

Structure
REQ-032 Package wb_pkg SHALL hold WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4 and the FSM state enum type.
REQ-033 Storage SHALL be a sub-module wb_sram_array: single-port, synchronous, with per-byte write enables and a registered read.
REQ-034 The FSM, wait counter and address decode SHALL reside in wb_sram_slave.

Verification
REQ-035 WAIT_CYCLES = 2: write adr 0x10, dat 0xDEADBEEF, sel 1111 -> ack 3 cycles after request; a following read of 0x10 returns 0xDEADBEEF with ack.
REQ-036 Write adr 0x20 dat 0x11223344 sel 1111, then write dat 0xAABBCCDD sel 0101 -> read returns 0x11BB33DD.
REQ-037 Read adr 0x00001000 with MEM_WORDS = 1024 -> o_wb_err pulse for 1 cycle, o_wb_ack 0, o_wb_dat 0.
REQ-038 Write 0x40 started, cyc dropped in the first WAIT cycle -> no ack/err; a later read of 0x40 returns the prior value.
REQ-039 i_rst_n low during WAIT of a write -> ack/err stay 0; FSM accepts a new request in the cycle after reset releases.
REQ-040 WAIT_CYCLES = 0, back-to-back reads with stb held high -> ack every 3rd cycle, one ack per request, never two consecutive ack cycles.
